cfg_chain_loader: RTL and testbench
===================================

# cfg_chain_loader

Configuration loader sitting directly upstream of the switch-box scan chain. It accepts configuration words over a valid/ready stream and serializes them LSB-first onto the chain's `prog_in`/`prog_en` pins. It optionally verifies the load by recirculating the chain once through its tail, which leaves the contents intact. It reports completion and any readback mismatch to the fabric configuration controller.

## Interface
- `CHAIN_LEN`, default 32: total chain length in bits. Must be a multiple of `WORD_W`.
- `WORD_W`, default 8: configuration word width.
- `prog_clk`  in  1  clock; same clock that drives the chain.
- `rst`  in  1  reset; asynchronous, active-low.
- `start`  in  1  one-cycle request to begin a load; ignored unless in IDLE.
- `verify_en`  in  1  sampled with `start`; 1 = run the VERIFY pass after LOAD.
- `cfg_data`  in  WORD_W  configuration word, bit 0 shifted first.
- `cfg_valid`  in  1  `cfg_data` valid.
- `cfg_ready`  out  1  loader accepts a word this cycle.
- `prog_in`  out  1  serial data to chain head.
- `prog_en`  out  1  chain shift enable.
- `chain_tail`  in  1  chain's `prog_out` (bit 0 of the last module).
- `busy`  out  1  high in LOAD and VERIFY.
- `done`  out  1  one-cycle pulse on return to IDLE after a completed load or verify.
- `verify_err`  out  1  sticky mismatch flag; cleared on `start`.

## Operation
- States: IDLE, LOAD, VERIFY.
  - IDLE -> LOAD on `start`: latches `verify_en`, clears the bit counter, the word buffer and `verify_err`.
  - LOAD -> VERIFY after CHAIN_LEN shifts if `verify_en` was latched; otherwise LOAD -> IDLE with a `done` pulse.
  - VERIFY -> IDLE with a `done` pulse after CHAIN_LEN shifts.
- LOAD handshake:
  - A word is accepted on `cfg_valid && cfg_ready`.
  - `cfg_ready` = LOAD && (word buffer empty || last buffered bit shifting this cycle) && words accepted < CHAIN_LEN/WORD_W. This allows gap-free streaming.
  - Accepted word bits go out on `prog_in`, one per cycle, bit 0 first, with `prog_en`=1.
- Stall: if the buffer is empty and `cfg_valid`=0, then `prog_en`=0, `prog_in`=0, and the chain holds. There is no timeout.
- Shadow: every bit driven in LOAD is also shifted into a CHAIN_LEN-bit shadow register.
- VERIFY:
  - `prog_en`=1 and `prog_in` = `chain_tail` (combinational path in this state only), so the chain rotates exactly once and is restored.
  - Each cycle, `chain_tail` is compared with `shadow[0]` and the shadow rotates.
  - Any mismatch sets `verify_err`, which holds until the next `start`.
- Bit ordering: the first bit shifted ends at chain bit 0; the last bit ends at bit CHAIN_LEN-1.
- Bit counter width: clog2(CHAIN_LEN+1). The terminal compare is against CHAIN_LEN, with no wrap.

## Timing
- Reset values: `cfg_ready`=0, `prog_in`=0, `prog_en`=0, `busy`=0, `done`=0, `verify_err`=0. State is IDLE; counters and shadow are 0.
- In LOAD, `prog_in`/`prog_en` are registered. A word accepted at edge t drives bit 0 during cycle t+1, and the chain samples it at edge t+2.
- Unstalled LOAD takes CHAIN_LEN+1 cycles from `start` to the final shift. VERIFY adds CHAIN_LEN cycles.
- `done` is asserted in the cycle after the final shift. `busy` falls in the same cycle.
- `start` while busy: ignored, with no effect on the transfer in progress.
- `rst` asserted mid-operation: immediate return to reset values. The chain itself is cleared by the same reset.
- `cfg_valid` held high after the final word: `cfg_ready` stays 0 and extra words are not consumed.

## Structure
- Shared header `cfg_defs.vh`: state encodings (IDLE/LOAD/VERIFY) and the default CHAIN_LEN/WORD_W localparams used by the fabric top and the benches.
- One sub-module, `cfg_serializer`: a WORD_W buffer plus bit counter with load/shift/empty/last outputs. The FSM, shadow and verify comparator stay in the top module.

## Test plan
- CHAIN_LEN=32, WORD_W=8, `verify_en`=0; stream 0x1B, 0xE4, 0x00, 0xFF back-to-back -> exactly 32 `prog_en` cycles with no gaps; chain shift register = 32'hFF00E41B; single `done` pulse.
- Same words with `cfg_valid` dropped for 5 cycles after the second word -> `prog_en` low for exactly those stall cycles; final chain value unchanged.
- `verify_en`=1, clean chain model -> 64 total shift cycles; chain still 32'hFF00E41B afterwards; `verify_err`=0.
- `verify_en`=1 with chain bit 10 forced to 0 after load -> `verify_err`=1 after VERIFY and stays high until the next `start`.
- `start` pulsed during LOAD -> ignored; `rst` low at bit 17 -> all outputs at reset values next cycle; a fresh `start` reloads correctly.
- `cfg_valid` held high after the 4th word -> `cfg_ready`=0; no 5th handshake occurs.

Source files
------------

// File: rtl/cfg_chain_loader_pkg.sv
// Shared definitions for the configuration chain loader: default geometry,
// FSM state encodings and a small state-decoding helper.
package cfg_chain_loader_pkg;

    // Default chain geometry used by the fabric top and the benches.
    localparam int DEF_CHAIN_LEN = 32;
    localparam int DEF_WORD_W    = 8;

    // Loader FSM states, kept as plain constants for legacy compatibility.
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_LOAD   = 2'd1;
    localparam logic [1:0] ST_VERIFY = 2'd2;

    // True while a transfer (load or verify pass) is in progress.
    function automatic logic state_is_active(input logic [1:0] state);
        return (state == ST_LOAD) || (state == ST_VERIFY);
    endfunction

endpackage

// File: rtl/cfg_serializer.sv
// Word-to-bit serializer feeding the chain head. The output bit register is
// the pin register itself, so a word accepted at edge t presents bit 0 during
// the following cycle and the remaining bits follow one per cycle.
module cfg_serializer
    import cfg_chain_loader_pkg::*;
#(
    parameter int WORD_W = DEF_WORD_W
) (
    input  logic              prog_clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              load,
    input  logic [WORD_W-1:0] data,
    output logic              bit_o,
    output logic              shift_o,
    output logic              empty_o,
    output logic              last_o
);

    localparam int CNT_W = $clog2(WORD_W + 1);

    logic [WORD_W-1:0] buf_q, buf_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              bit_q, bit_d;
    logic              shift_q, shift_d;

    // Next-state: load a fresh word, or move the next buffered bit onto the pin.
    always_comb begin
        buf_d   = buf_q;
        cnt_d   = cnt_q;
        bit_d   = 1'b0;
        shift_d = 1'b0;
        if (clr) begin
            buf_d = '0;
            cnt_d = '0;
        end else if (load) begin
            bit_d   = data[0];
            shift_d = 1'b1;
            buf_d   = {1'b0, data[WORD_W-1:1]};
            cnt_d   = CNT_W'(WORD_W - 1);
        end else if (cnt_q != '0) begin
            bit_d   = buf_q[0];
            shift_d = 1'b1;
            buf_d   = {1'b0, buf_q[WORD_W-1:1]};
            cnt_d   = cnt_q - CNT_W'(1);
        end else begin
            buf_d = buf_q;
            cnt_d = cnt_q;
        end
    end

    // Buffer, remaining-bit count and pin registers.
    always_ff @(posedge prog_clk or negedge rst) begin
        if (!rst) begin
            buf_q   <= '0;
            cnt_q   <= '0;
            bit_q   <= 1'b0;
            shift_q <= 1'b0;
        end else begin
            buf_q   <= buf_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
        end
    end

    // Empty: nothing on the pin and nothing buffered. Last: the final bit of
    // the current word is on the pin, so a new word can be taken without a gap.
    assign bit_o   = bit_q;
    assign shift_o = shift_q;
    assign empty_o = (cnt_q == '0) && !shift_q;
    assign last_o  = (cnt_q == '0) && shift_q;

endmodule

// File: rtl/cfg_chain_loader.sv
// Configuration loader for the switch-box scan chain. Streams words from a
// valid/ready interface LSB-first into the chain, keeps a shadow copy of what
// was shifted, and optionally rotates the chain once through its tail to
// verify the contents without disturbing them. CHAIN_LEN must be a multiple
// of WORD_W.
module cfg_chain_loader
    import cfg_chain_loader_pkg::*;
#(
    parameter int CHAIN_LEN = DEF_CHAIN_LEN,
    parameter int WORD_W    = DEF_WORD_W
) (
    input  logic              prog_clk,
    input  logic              rst,
    input  logic              start,
    input  logic              verify_en,
    input  logic [WORD_W-1:0] cfg_data,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    output logic              prog_in,
    output logic              prog_en,
    input  logic              chain_tail,
    output logic              busy,
    output logic              done,
    output logic              verify_err
);

    localparam int NUM_WORDS  = CHAIN_LEN / WORD_W;
    localparam int BIT_CNT_W  = $clog2(CHAIN_LEN + 1);
    localparam int WORD_CNT_W = $clog2(NUM_WORDS + 1);

    logic [1:0]            state_q, state_d;
    logic                  verify_sel_q, verify_sel_d;
    logic [BIT_CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [WORD_CNT_W-1:0] word_cnt_q, word_cnt_d;
    logic [CHAIN_LEN-1:0]  shadow_q, shadow_d;
    logic                  done_q, done_d;
    logic                  verify_err_q, verify_err_d;

    logic                  ser_bit_s;
    logic                  ser_shift_s;
    logic                  ser_empty_s;
    logic                  ser_last_s;
    logic                  start_load_s;
    logic                  accept_s;
    logic                  cfg_ready_s;
    logic [BIT_CNT_W-1:0]  bit_cnt_inc_s;
    logic                  last_shift_s;

    // Ready only while loading, when the serializer can take a word without
    // a gap, and while the chain still needs more words.
    assign cfg_ready_s   = (state_q == ST_LOAD) && (ser_empty_s || ser_last_s)
                           && (word_cnt_q < WORD_CNT_W'(NUM_WORDS));
    assign accept_s      = cfg_valid && cfg_ready_s;
    assign start_load_s  = (state_q == ST_IDLE) && start;
    assign bit_cnt_inc_s = bit_cnt_q + BIT_CNT_W'(1);
    assign last_shift_s  = (bit_cnt_inc_s == BIT_CNT_W'(CHAIN_LEN));

    cfg_serializer #(
        .WORD_W (WORD_W)
    ) u_serializer (
        .prog_clk (prog_clk),
        .rst      (rst),
        .clr      (start_load_s),
        .load     (accept_s),
        .data     (cfg_data),
        .bit_o    (ser_bit_s),
        .shift_o  (ser_shift_s),
        .empty_o  (ser_empty_s),
        .last_o   (ser_last_s)
    );

    // FSM, shift counting, shadow capture/rotation and verify comparison.
    always_comb begin
        state_d      = state_q;
        verify_sel_d = verify_sel_q;
        bit_cnt_d    = bit_cnt_q;
        word_cnt_d   = word_cnt_q;
        shadow_d     = shadow_q;
        verify_err_d = verify_err_q;
        done_d       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d      = ST_LOAD;
                    verify_sel_d = verify_en;
                    bit_cnt_d    = '0;
                    word_cnt_d   = '0;
                    verify_err_d = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (accept_s) begin
                    word_cnt_d = word_cnt_q + WORD_CNT_W'(1);
                end else begin
                    word_cnt_d = word_cnt_q;
                end
                if (ser_shift_s) begin
                    shadow_d = {ser_bit_s, shadow_q[CHAIN_LEN-1:1]};
                    if (last_shift_s) begin
                        bit_cnt_d = '0;
                        if (verify_sel_q) begin
                            state_d = ST_VERIFY;
                        end else begin
                            state_d = ST_IDLE;
                            done_d  = 1'b1;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_inc_s;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q;
                end
            end
            ST_VERIFY: begin
                // Shadow rotates in step with the chain so shadow[0] always
                // predicts the bit now at the tail.
                shadow_d = {shadow_q[0], shadow_q[CHAIN_LEN-1:1]};
                if (chain_tail != shadow_q[0]) begin
                    verify_err_d = 1'b1;
                end else begin
                    verify_err_d = verify_err_q;
                end
                if (last_shift_s) begin
                    bit_cnt_d = '0;
                    state_d   = ST_IDLE;
                    done_d    = 1'b1;
                end else begin
                    bit_cnt_d = bit_cnt_inc_s;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                bit_cnt_d = '0;
            end
        endcase
    end

    // Loader state registers.
    always_ff @(posedge prog_clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            verify_sel_q <= 1'b0;
            bit_cnt_q    <= '0;
            word_cnt_q   <= '0;
            shadow_q     <= '0;
            done_q       <= 1'b0;
            verify_err_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            verify_sel_q <= verify_sel_d;
            bit_cnt_q    <= bit_cnt_d;
            word_cnt_q   <= word_cnt_d;
            shadow_q     <= shadow_d;
            done_q       <= done_d;
            verify_err_q <= verify_err_d;
        end
    end

    // In VERIFY the tail is fed straight back to the head so the chain
    // rotates once and ends up unchanged; in LOAD the pin registers drive.
    assign prog_en    = (state_q == ST_VERIFY) ? 1'b1
                      : ((state_q == ST_LOAD) ? ser_shift_s : 1'b0);
    assign prog_in    = (state_q == ST_VERIFY) ? chain_tail
                      : ((state_q == ST_LOAD) ? ser_bit_s : 1'b0);
    assign cfg_ready  = cfg_ready_s;
    assign busy       = state_is_active(state_q);
    assign done       = done_q;
    assign verify_err = verify_err_q;

endmodule

// File: tb/tb_cfg_chain_loader.sv
// Self-checking bench for cfg_chain_loader: a 32-bit chain model driven by
// the DUT pins, a bit-queue behavioural model checked every cycle, and
// directed loads with hand-computed final chain values.
module tb_cfg_chain_loader;

    logic       prog_clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       verify_en = 1'b0;
    logic [7:0] cfg_data = 8'h00;
    logic       cfg_valid = 1'b0;
    logic       cfg_ready, prog_in, prog_en, busy, done, verify_err;
    logic       chain_tail;
    logic [31:0] chain;
    int          cs;
    logic        corrupt_en = 1'b0;

    int checks = 0;
    int errors = 0;

    // Behavioural model state: 0 idle, 1 load, 2 verify.
    int  m_phase = 0;
    bit  m_ver = 1'b0;
    bit  m_err = 1'b0;
    bit  m_done = 1'b0;
    bit  q[$];
    bit  m_shadow[32];
    int  m_words = 0;
    int  m_shifts = 0;
    int  en_cycles = 0;
    int  first_en = -1;
    int  last_en = -1;
    int  hs_cnt = 0;
    int  cyc = 0;

    cfg_chain_loader #(.CHAIN_LEN(32), .WORD_W(8)) dut (
        .prog_clk   (prog_clk),
        .rst        (rst),
        .start      (start),
        .verify_en  (verify_en),
        .cfg_data   (cfg_data),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .prog_in    (prog_in),
        .prog_en    (prog_en),
        .chain_tail (chain_tail),
        .busy       (busy),
        .done       (done),
        .verify_err (verify_err)
    );

    always #5 prog_clk = ~prog_clk;

    function automatic logic [31:0] chain_next(input logic [31:0] c, input logic pin,
                                               input logic en, input logic corrupt, input int n);
        logic [31:0] r;
        r = c;
        if (en) begin
            r = {pin, c[31:1]};
            if (corrupt && n == 31) r[10] = 1'b0;
        end
        return r;
    endfunction

    // Scan chain model: shifts toward bit 0, optional bit-10 upset at end of load.
    always @(posedge prog_clk or negedge rst) begin
        if (!rst) begin
            chain <= 32'd0;
            cs    <= 0;
        end else begin
            chain <= chain_next(chain, prog_in, prog_en, corrupt_en, cs);
            if (start) cs <= 0;
            else if (prog_en) cs <= cs + 1;
        end
    end
    assign chain_tail = chain[0];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    task automatic compare_cycle();
        logic e_ready, e_en, e_in;
        cyc++;
        if (!rst) begin
            check("reset_outputs", {26'd0, cfg_ready, prog_in, prog_en, busy, done, verify_err}, 32'd0);
            m_phase = 0; m_err = 1'b0; m_done = 1'b0; q.delete(); m_words = 0; m_shifts = 0;
        end else begin
            e_ready = (m_phase == 1) && (m_words < 4) && (q.size() <= 1);
            e_en    = (m_phase == 2) || ((m_phase == 1) && (q.size() > 0));
            e_in    = (m_phase == 2) ? chain_tail : (((m_phase == 1) && (q.size() > 0)) ? q[0] : 1'b0);
            check("cfg_ready",  32'(cfg_ready),  32'(e_ready));
            check("prog_en",    32'(prog_en),    32'(e_en));
            check("prog_in",    32'(prog_in),    32'(e_in));
            check("busy",       32'(busy),       32'(m_phase != 0));
            check("done",       32'(done),       32'(m_done));
            check("verify_err", 32'(verify_err), 32'(m_err));
            if (prog_en) begin
                en_cycles++;
                if (first_en < 0) first_en = cyc;
                last_en = cyc;
            end
            if (cfg_valid && cfg_ready) hs_cnt++;
            m_done = 1'b0;
            case (m_phase)
                0: begin
                    if (start) begin
                        m_phase = 1; m_ver = verify_en; m_err = 1'b0; q.delete();
                        m_words = 0; m_shifts = 0;
                        en_cycles = 0; first_en = -1; last_en = -1; hs_cnt = 0;
                    end
                end
                1: begin
                    if (e_en) begin
                        m_shadow[m_shifts] = q.pop_front();
                        m_shifts++;
                    end
                    if (cfg_valid && e_ready) begin
                        for (int i = 0; i < 8; i++) q.push_back(cfg_data[i]);
                        m_words++;
                    end
                    if (m_shifts == 32) begin
                        m_shifts = 0;
                        if (m_ver) m_phase = 2;
                        else begin m_phase = 0; m_done = 1'b1; end
                    end
                end
                2: begin
                    if (chain_tail !== m_shadow[m_shifts]) m_err = 1'b1;
                    m_shifts++;
                    if (m_shifts == 32) begin m_phase = 0; m_done = 1'b1; end
                end
                default: m_phase = 0;
            endcase
        end
    endtask

    initial begin
        forever begin
            @(negedge prog_clk);
            compare_cycle();
        end
    end

    task automatic send_word(input logic [7:0] w);
        int n;
        n = 0;
        cfg_data  = w;
        cfg_valid = 1'b1;
        @(negedge prog_clk);
        while (!cfg_ready && n < 200) begin
            @(negedge prog_clk);
            n++;
        end
        if (n >= 200) timeout_fail("send_word");
        @(posedge prog_clk); #1;
    endtask

    // Drop valid from the first ready cycle for five cycles in total.
    task automatic stall_gap();
        int n;
        n = 0;
        cfg_valid = 1'b0;
        @(negedge prog_clk);
        while (!cfg_ready && n < 200) begin
            @(negedge prog_clk);
            n++;
        end
        if (n >= 200) timeout_fail("stall_wait");
        repeat (4) @(negedge prog_clk);
        @(posedge prog_clk); #1;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        @(negedge prog_clk);
        while (!done && n < 300) begin
            @(negedge prog_clk);
            n++;
        end
        if (n >= 300) timeout_fail("wait_done");
        @(posedge prog_clk); #1;
    endtask

    task automatic run_load(input bit ver, input bit stall, input bit corrupt,
                            input logic [31:0] exp_chain, input int exp_en,
                            input int exp_span, input bit exp_err);
        logic [7:0] words [4];
        words = '{8'h1B, 8'hE4, 8'h00, 8'hFF};
        corrupt_en = corrupt;
        verify_en  = ver;
        start      = 1'b1;
        @(posedge prog_clk); #1;
        start     = 1'b0;
        verify_en = 1'b0;
        check("verify_err_cleared", 32'(verify_err), 32'd0);
        for (int i = 0; i < 4; i++) begin
            if (stall && i == 2) stall_gap();
            send_word(words[i]);
        end
        // Keep offering a fifth word; it must never be taken.
        cfg_data  = 8'h5A;
        cfg_valid = 1'b1;
        wait_done();
        cfg_valid = 1'b0;
        cfg_data  = 8'h00;
        check("chain_value",  chain, exp_chain);
        check("shift_cycles", 32'(en_cycles), 32'(exp_en));
        check("shift_span",   32'(last_en - first_en + 1), 32'(exp_span));
        check("handshakes",   32'(hs_cnt), 32'd4);
        check("verify_err_final", 32'(verify_err), 32'(exp_err));
        corrupt_en = 1'b0;
    endtask

    task automatic reset_midload();
        int n;
        n = 0;
        start = 1'b1;
        @(posedge prog_clk); #1;
        start = 1'b0;
        send_word(8'h1B);
        start     = 1'b1;
        verify_en = 1'b1;
        @(posedge prog_clk); #1;
        start     = 1'b0;
        verify_en = 1'b0;
        check("start_ignored_busy", 32'(busy), 32'd1);
        send_word(8'hE4);
        send_word(8'h00);
        cfg_valid = 1'b0;
        while (en_cycles < 17 && n < 100) begin
            @(posedge prog_clk); #1;
            n++;
        end
        if (n >= 100) timeout_fail("wait_bit17");
        rst = 1'b0;
        #1;
        check("async_reset_busy", 32'(busy), 32'd0);
        repeat (2) @(posedge prog_clk);
        #1;
        check("chain_cleared", chain, 32'd0);
        rst = 1'b1;
        @(posedge prog_clk); #1;
    endtask

    initial begin
        repeat (3) @(posedge prog_clk);
        #1;
        rst = 1'b1;
        @(posedge prog_clk); #1;
        check("idle_after_reset", {26'd0, cfg_ready, prog_in, prog_en, busy, done, verify_err}, 32'd0);

        run_load(1'b0, 1'b0, 1'b0, 32'hFF00E41B, 32, 32, 1'b0);
        run_load(1'b0, 1'b1, 1'b0, 32'hFF00E41B, 32, 37, 1'b0);
        run_load(1'b1, 1'b0, 1'b0, 32'hFF00E41B, 64, 64, 1'b0);
        run_load(1'b1, 1'b0, 1'b1, 32'hFF00E01B, 64, 64, 1'b1);
        repeat (3) @(posedge prog_clk);
        #1;
        check("verify_err_sticky", 32'(verify_err), 32'd1);

        reset_midload();
        run_load(1'b0, 1'b0, 1'b0, 32'hFF00E41B, 32, 32, 1'b0);

        repeat (2) @(posedge prog_clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
